execute: RTL
============

EXECUTE -- requirements
Module: execute

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port stallE, input, 1 bit: when high, the ID/EX registers hold their values.
REQ-004 The block SHALL have port flushE, input, 1 bit: when high, the ID/EX registers load a bubble.
REQ-005 The block SHALL have ports jumpD, RegWriteD, MemWriteD, ALUSrcD, RegDstD, inputs, 1 bit each: decode control flags.
REQ-006 The block SHALL have ports MemtoRegD and ALUControlD, inputs, 4 bits each: result select and ALU operation.
REQ-007 The block SHALL have port MDOpD, input, 2 bits: 00 none, 01 MULT (signed), 10 MULTU, 11 DIVU.
REQ-008 The block SHALL have ports RsD, RtD, RdD, inputs, 5 bits each: register specifiers.
REQ-009 The block SHALL have ports RD1D, RD2D, SignImmD, PCPlus4D, inputs, 32 bits each: decode operands.
REQ-010 The block SHALL have ports ForwardAE and ForwardBE, inputs, 2 bits each: 00 register, 01 ResultW, 10 ALUMultOutM.
REQ-011 The block SHALL have ports ResultW and ALUMultOutM, inputs, 32 bits each: forwarding sources.
REQ-012 The block SHALL have ports jumpE, RegWriteE, MemWriteE, outputs, 1 bit each, and MemtoRegE, output, 4 bits: registered controls to the memory stage.
REQ-013 The block SHALL have ports WriteRegE, RsE, RtE, outputs, 5 bits each: destination register and hazard specifiers.
REQ-014 The block SHALL have ports ALUMultOutE, WriteDataE, PCPlus4E, outputs, 32 bits each: result, store data and link PC.
REQ-015 The block SHALL have port mdBusyE, output, 1 bit: the multiply/divide unit is busy.

Function
REQ-016 The ID/EX register SHALL take priority flushE over stallE over load; a bubble SHALL zero all controls and MDOp.
REQ-017 SrcAE SHALL be the forwarded RD1 value; WriteDataE SHALL be the forwarded RD2 value; SrcBE SHALL be SignImm when ALUSrc=1, else WriteDataE; ForwardxE=11 SHALL select the register value.
REQ-018 WriteRegE SHALL be Rd when RegDst=1, else Rt.
REQ-019 ALUControl decoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0 or 1), 1000 HI, 1001 LO; all other codes SHALL produce 0.
REQ-020 ALU arithmetic SHALL wrap modulo 2^32 with no overflow detection.
REQ-021 ALUMultOutE SHALL be combinational from the current ID/EX register contents and the forwarding inputs, so it is valid in the same cycle.
REQ-022 The MD unit SHALL be a state machine with states IDLE and BUSY; a 1-bit issued flag SHALL be cleared whenever the ID/EX register loads.
REQ-023 In IDLE, when MDOpE!=0 and issued=0, the unit SHALL latch SrcAE/SrcBE, set issued=1, load count=31 and enter BUSY.
REQ-024 In BUSY, the unit SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle; at count=0 it SHALL write HI/LO and return to IDLE, giving 32 busy cycles.
REQ-025 MULT SHALL produce the signed 64-bit product (HI = upper word, LO = lower word); MULTU SHALL produce the unsigned product; DIVU SHALL produce LO = quotient and HI = remainder.
REQ-026 DIVU by zero SHALL yield LO=32'hFFFFFFFF and HI=dividend after the normal 32 cycles.
REQ-027 mdBusyE SHALL equal (state==BUSY); HI/LO reads SHALL return the committed values (the hazard unit stalls on mdBusyE).
REQ-028 flushE and stallE SHALL NOT abort an MD operation in BUSY.

Reset
REQ-029 On rst low, all ID/EX registers, HI, LO, count and issued SHALL clear to 0, state SHALL become IDLE, and every registered output SHALL be 0, asynchronously, including mid-operation.
REQ-030 After rst rises, the first rising edge SHALL load normally.

Configuration
REQ-031 With FAST_MULT_EN defined, MULT/MULTU SHALL write HI/LO at the rising edge that starts the operation, without entering BUSY (mdBusyE stays 0); DIVU SHALL be unchanged.
REQ-032 Without FAST_MULT_EN, all MD operations SHALL use the 32-cycle iterative path.

Verification
REQ-033 The bench SHALL check: RD1=5, RD2=7, ADD, no forwarding -> ALUMultOutE=12, WriteDataE=7.
REQ-034 The bench SHALL check: ForwardAE=10, ALUMultOutM=0x10, SUB, RD2=1 -> ALUMultOutE=0xF; SLT with -1 vs 1 -> 1.
REQ-035 The bench SHALL check: MULT 0xFFFFFFFE x 3 -> mdBusyE high for 32 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA; with FAST_MULT_EN, the same values appear after 1 edge and mdBusyE stays 0.
REQ-036 The bench SHALL check: DIVU 100/7 -> LO=14, HI=2; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
REQ-037 The bench SHALL check: rst low at busy cycle 10 of a DIVU -> state IDLE, mdBusyE=0, HI=LO=0 immediately.
REQ-038 The bench SHALL check: MULT held in E by stallE for 40 cycles -> exactly one operation executes (issued flag) and flushE with stallE both high -> bubble.

Source files
------------

// File: rtl/execute_if.sv
// Execute-stage bus: decode-side inputs, forwarding inputs, hazard controls
// and the execute-stage outputs. Debug taps (mdStateE, mdIssuedE, hiE, loE)
// expose the multiply/divide unit state and its committed HI/LO values.
//
// Hazard control semantics: stallE and flushE are sampled on each rising clk.
// flushE=1 loads a bubble (all zero), stallE=1 with flushE=0 holds the ID/EX
// register, both low loads the decode values. mdBusyE is the request back to
// the hazard unit to stall; it is never gated by stallE/flushE.
interface execute_if;
  logic        stallE, flushE;
  logic        jumpD, RegWriteD, MemWriteD, ALUSrcD, RegDstD;
  logic [3:0]  MemtoRegD, ALUControlD;
  logic [1:0]  MDOpD;
  logic [4:0]  RsD, RtD, RdD;
  logic [31:0] RD1D, RD2D, SignImmD, PCPlus4D;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUMultOutM;
  logic        jumpE, RegWriteE, MemWriteE;
  logic [3:0]  MemtoRegE;
  logic [4:0]  WriteRegE, RsE, RtE;
  logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;
  logic        mdBusyE;
  logic        mdStateE, mdIssuedE;
  logic [31:0] hiE, loE;

  modport slave (
    input  stallE, flushE, jumpD, RegWriteD, MemWriteD, ALUSrcD, RegDstD,
           MemtoRegD, ALUControlD, MDOpD, RsD, RtD, RdD, RD1D, RD2D, SignImmD,
           PCPlus4D, ForwardAE, ForwardBE, ResultW, ALUMultOutM,
    output jumpE, RegWriteE, MemWriteE, MemtoRegE, WriteRegE, RsE, RtE,
           ALUMultOutE, WriteDataE, PCPlus4E, mdBusyE, mdStateE, mdIssuedE,
           hiE, loE
  );

  modport master (
    output stallE, flushE, jumpD, RegWriteD, MemWriteD, ALUSrcD, RegDstD,
           MemtoRegD, ALUControlD, MDOpD, RsD, RtD, RdD, RD1D, RD2D, SignImmD,
           PCPlus4D, ForwardAE, ForwardBE, ResultW, ALUMultOutM,
    input  jumpE, RegWriteE, MemWriteE, MemtoRegE, WriteRegE, RsE, RtE,
           ALUMultOutE, WriteDataE, PCPlus4E, mdBusyE, mdStateE, mdIssuedE,
           hiE, loE
  );
endinterface

// File: rtl/execute.sv
// Execute stage: ID/EX register, operand forwarding, ALU and an iterative
// multiply/divide unit (32 cycles, shift-add multiply, restoring divide).
// Optional macro FAST_MULT_EN: MULT/MULTU commit HI/LO in a single edge;
// DIVU always stays iterative.
module execute (
  input  logic clk,
  input  logic rst,
  execute_if.slave ex
);
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_MULTU = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_t;

  // ID/EX register contents
  logic        jumpE, RegWriteE, MemWriteE, ALUSrcE, RegDstE;
  logic [3:0]  MemtoRegE, ALUControlE;
  logic [1:0]  MDOpE;
  logic [4:0]  RsE, RtE, RdE;
  logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E;

  // operand path
  logic [31:0] srcAE, srcBE, writeDataE, aluOut;

  // multiply/divide unit
  mdState_t    state;
  logic        issued, mdDiv, mdNeg;
  logic [4:0]  count;
  logic [31:0] hiReg, loReg, mdA, mdQ, mdM;
  logic        idexLoad, mdStart, fastMul;
  logic [63:0] fastProd, mulProd, mulRes;
  logic [32:0] mulSum, divShift;
  logic        divGe;
  logic [31:0] mulNextA, mulNextQ, divDiff, divNextA, divNextQ, absA, absB;

  // a flush is also a load (of a bubble); only a plain stall holds
  assign idexLoad = ex.flushE || !ex.stallE;

  // ID/EX register: flush beats stall beats load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || ex.flushE) begin
      jumpE <= 1'b0; RegWriteE <= 1'b0; MemWriteE <= 1'b0; ALUSrcE <= 1'b0;
      RegDstE <= 1'b0; MemtoRegE <= '0; ALUControlE <= '0; MDOpE <= '0;
      RsE <= '0; RtE <= '0; RdE <= '0;
      RD1E <= '0; RD2E <= '0; SignImmE <= '0; PCPlus4E <= '0;
    end else if (!ex.stallE) begin
      jumpE <= ex.jumpD; RegWriteE <= ex.RegWriteD; MemWriteE <= ex.MemWriteD;
      ALUSrcE <= ex.ALUSrcD; RegDstE <= ex.RegDstD; MemtoRegE <= ex.MemtoRegD;
      ALUControlE <= ex.ALUControlD; MDOpE <= ex.MDOpD;
      RsE <= ex.RsD; RtE <= ex.RtD; RdE <= ex.RdD;
      RD1E <= ex.RD1D; RD2E <= ex.RD2D; SignImmE <= ex.SignImmD;
      PCPlus4E <= ex.PCPlus4D;
    end
  end

  // forwarding muxes and ALU; 11 falls back to the register value
  always_comb begin
    case (ex.ForwardAE)
      2'b01:   srcAE = ex.ResultW;
      2'b10:   srcAE = ex.ALUMultOutM;
      default: srcAE = RD1E;
    endcase
    case (ex.ForwardBE)
      2'b01:   writeDataE = ex.ResultW;
      2'b10:   writeDataE = ex.ALUMultOutM;
      default: writeDataE = RD2E;
    endcase
    srcBE = ALUSrcE ? SignImmE : writeDataE;
    case (ALUControlE)
      4'b0000: aluOut = srcAE & srcBE;
      4'b0001: aluOut = srcAE | srcBE;
      4'b0010: aluOut = srcAE + srcBE;
      4'b0110: aluOut = srcAE - srcBE;
      4'b0111: aluOut = {31'b0, $signed(srcAE) < $signed(srcBE)};
      4'b1000: aluOut = hiReg;
      4'b1001: aluOut = loReg;
      default: aluOut = '0;
    endcase
  end

  // one iteration step of multiply (shift-add) and divide (restoring)
  always_comb begin
    mulSum   = {1'b0, mdA} + (mdQ[0] ? {1'b0, mdM} : 33'd0);
    mulNextA = mulSum[32:1];
    mulNextQ = {mulSum[0], mdQ[31:1]};
    mulProd  = {mulNextA, mulNextQ};
    mulRes   = mdNeg ? -mulProd : mulProd;
    divShift = {mdA, mdQ[31]};
    divGe    = divShift >= {1'b0, mdM};
    divDiff  = divShift[31:0] - mdM;
    divNextA = divGe ? divDiff : divShift[31:0];
    divNextQ = {mdQ[30:0], divGe};
    // signed multiply runs on magnitudes and fixes the sign at the end
    absA     = (MDOpE == MD_MULT && srcAE[31]) ? -srcAE : srcAE;
    absB     = (MDOpE == MD_MULT && srcBE[31]) ? -srcBE : srcBE;
  end

  assign mdStart = (state == IDLE) && (MDOpE != 2'b00) && !issued;

`ifdef FAST_MULT_EN
  assign fastMul  = (MDOpE == MD_MULT) || (MDOpE == MD_MULTU);
  assign fastProd = (MDOpE == MD_MULT)
                  ? $signed({{32{srcAE[31]}}, srcAE}) * $signed({{32{srcBE[31]}}, srcBE})
                  : {32'b0, srcAE} * {32'b0, srcBE};
`else
  assign fastMul  = 1'b0;
  assign fastProd = '0;
`endif

  // MD state machine; ID/EX loads clear issued so the next op can start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; issued <= 1'b0; count <= '0; hiReg <= '0; loReg <= '0;
      mdA <= '0; mdQ <= '0; mdM <= '0; mdDiv <= 1'b0; mdNeg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mdStart) begin
            issued <= 1'b1;
            if (fastMul) begin
              hiReg <= fastProd[63:32];
              loReg <= fastProd[31:0];
            end else begin
              mdDiv <= (MDOpE == MD_DIVU);
              mdNeg <= (MDOpE == MD_MULT) && (srcAE[31] ^ srcBE[31]);
              mdA   <= '0;
              mdQ   <= (MDOpE == MD_DIVU) ? srcAE : absA;
              mdM   <= (MDOpE == MD_DIVU) ? srcBE : absB;
              count <= 5'd31;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          mdA <= mdDiv ? divNextA : mulNextA;
          mdQ <= mdDiv ? divNextQ : mulNextQ;
          if (count == 5'd0) begin
            hiReg <= mdDiv ? divNextA : mulRes[63:32];
            loReg <= mdDiv ? divNextQ : mulRes[31:0];
            state <= IDLE;
          end else begin
            count <= count - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (idexLoad) issued <= 1'b0;
    end
  end

  assign ex.jumpE       = jumpE;
  assign ex.RegWriteE   = RegWriteE;
  assign ex.MemWriteE   = MemWriteE;
  assign ex.MemtoRegE   = MemtoRegE;
  assign ex.WriteRegE   = RegDstE ? RdE : RtE;
  assign ex.RsE         = RsE;
  assign ex.RtE         = RtE;
  assign ex.ALUMultOutE = aluOut;
  assign ex.WriteDataE  = writeDataE;
  assign ex.PCPlus4E    = PCPlus4E;
  assign ex.mdBusyE     = (state == BUSY);
  assign ex.mdStateE    = state;
  assign ex.mdIssuedE   = issued;
  assign ex.hiE         = hiReg;
  assign ex.loE         = loReg;
endmodule
